// File: rtl/cache_access_gen.sv
// CPU-side access generator: drives a strided (or, with CACHE_GEN_LFSR_EN, LFSR)
// address sequence into the direct-mapped cache and tallies the registered hit/miss results.
module cache_access_gen #(
  parameter int ADDR_WIDTH = 11,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [CNT_WIDTH-1:0]  count,
`ifdef CACHE_GEN_LFSR_EN
  input  logic                  mode,
`endif
  input  logic                  hit,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state, state_d;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [ADDR_WIDTH-1:0] first_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  score_v;
`ifdef CACHE_GEN_LFSR_EN
  logic                  mode_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    done    = 1'b0;
    case (state)
      IDLE:  if (start) state_d = (count == '0) ? DONE : ISSUE;
      ISSUE: if (remaining == CNT_WIDTH'(1)) state_d = DRAIN;
      DRAIN: state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // LFSR taps {10,8} give x^11+x^9+1; an all-zero seed would lock the LFSR, so it becomes 1.
  always_comb begin
    first_addr = base_addr;
    next_addr  = addr + stride_q;
`ifdef CACHE_GEN_LFSR_EN
    if (mode && base_addr == '0) first_addr = ADDR_WIDTH'(1);
    if (mode_q)
      next_addr = {addr[ADDR_WIDTH-2:0], addr[ADDR_WIDTH-1] ^ addr[ADDR_WIDTH-3]};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      busy       <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      remaining  <= '0;
      stride_q   <= '0;
      score_v    <= 1'b0;
`ifdef CACHE_GEN_LFSR_EN
      mode_q     <= 1'b0;
`endif
    end else begin
      if (score_v) begin
        if (hit) hit_count  <= hit_count + CNT_WIDTH'(1);
        else     miss_count <= miss_count + CNT_WIDTH'(1);
      end
      score_v <= (state == ISSUE);
      case (state)
        IDLE: begin
          if (start) begin
            hit_count  <= '0;
            miss_count <= '0;
            if (count != '0) begin
              addr      <= first_addr;
              remaining <= count;
              stride_q  <= stride;
              busy      <= 1'b1;
`ifdef CACHE_GEN_LFSR_EN
              mode_q    <= mode;
`endif
            end
          end
        end
        ISSUE: begin
          addr      <= next_addr;
          remaining <= remaining - CNT_WIDTH'(1);
        end
        DRAIN: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cache_access_gen.md
Name: cache_access_gen

Overview:
- CPU-side access generator for the direct-mapped cache model: the initiator end of the cache's address/hit interface.
- On a start command it drives a programmed sequence of 11-bit addresses into the cache, one per clock.
- It pairs each registered hit/miss result with the access that produced it and accumulates hit and miss totals.
- It signals completion with a one-cycle done pulse; used by benches and the top-level to measure hit rate for a stride pattern.

Parameters:
- ADDR_WIDTH, 11, width of the address driven to the cache (tag 10:8, index 7:4, offset 3:0).
- CNT_WIDTH, 16, width of the access count and of the hit/miss counters.

Ports:
- clk  input  1  clock; every register samples on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle command; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first address of the run; sampled with start.
- stride  input  ADDR_WIDTH  address increment per access; sampled with start.
- count  input  CNT_WIDTH  number of accesses in the run; sampled with start.
- hit  input  1  registered hit flag from the cache; refers to the address the cache sampled on the previous edge.
- addr  output  ADDR_WIDTH  address presented to the cache (registered).
- busy  output  1  high from the start edge until the edge that raises done.
- done  output  1  one-cycle pulse at the end of a run.
- hit_count  output  CNT_WIDTH  hits in the current or last run.
- miss_count  output  CNT_WIDTH  misses in the current or last run.

Behaviour:
- Reset values (asynchronous): addr=0, busy=0, done=0, hit_count=0, miss_count=0, state=IDLE, remaining=0, score_v=0.
- IDLE, start=1 and count!=0:
  - addr<=base_addr, remaining<=count, stride latched, counters cleared, busy<=1, state<=ISSUE.
- IDLE, start=1 and count==0:
  - counters cleared, state<=DONE. No access is issued and busy stays 0.
- ISSUE, on each edge:
  - The cache samples the current addr; score_v<=1; addr<=addr+stride, truncated to ADDR_WIDTH so it wraps modulo 2^11; remaining<=remaining-1.
  - When remaining==1 at the edge, state<=DRAIN.
- Scoring, every edge with score_v=1:
  - hit=1 increments hit_count, otherwise miss_count increments. score_v then follows "state==ISSUE".
  - Counters cannot overflow because hit_count+miss_count<=count.
- DRAIN: scores the final result; state<=DONE, busy<=0.
- DONE: done=1 for exactly one cycle, then state<=IDLE.
- Latency: start sampled at edge 0 -> cache samples accesses at edges 1..N -> scored at edges 2..N+1 -> done high in the cycle after edge N+1. hit_count+miss_count==N when done=1.
- Counters are held stable from done until the next accepted start.
- start outside IDLE (ISSUE, DRAIN or DONE) is ignored; base_addr, stride and count are not re-sampled.
- In IDLE, addr holds its last value. The cache has no enable and re-samples it each cycle. This is harmless (a repeat access to a resident line leaves the cache unchanged) and is never counted.
- stride=0 is legal: every access uses base_addr.
- rst mid-run: immediate return to reset values; the in-flight result is discarded; no done pulse.

Optional Feature:
- Macro: CACHE_GEN_LFSR_EN.
- When defined:
  - Adds input mode (1 bit), sampled with start.
  - mode=1: the address sequence is an 11-bit Fibonacci LFSR, polynomial x^11+x^9+1, next = {addr[9:0], addr[10]^addr[8]}, seeded with base_addr. A seed of 0 is replaced by 11'h001. stride is ignored.
  - mode=0: stride sequencing exactly as above.
- When not defined: no mode port; stride sequencing only.

Test Plan:
- After reset and cache initialisation, start base=0x100 stride=4 count=8:
  - addresses 0x100..0x11C;
  - hit_count=6, miss_count=2;
  - done pulse exactly 9 cycles after the start edge; busy high for 9 cycles.
- start base=0x040 stride=0x100 count=8: all eight map to index 4 with tags 0..7 -> miss_count=8, hit_count=0. Repeat the identical run -> 8 misses again (thrash).
- start count=0: done=1 in the cycle after the start edge; busy stays 0; counters=0; addr unchanged.
- start base=0x7F8 stride=8 count=3:
  - addresses 0x7F8, 0x000, 0x008 (wrap);
  - start re-pulsed during ISSUE with other values is ignored and totals reflect the first run only.
- rst asserted at the 4th ISSUE cycle of a count=10 run: outputs return to 0 asynchronously with no done pulse; a following start count=2 completes normally with hit_count+miss_count=2.
- With CACHE_GEN_LFSR_EN: mode=1 base=0 count=3 -> addresses 0x001, 0x002, 0x004; done after 4 cycles.
